// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_CNT_W   = $clog2(DIV_WIDTH);
    localparam int unsigned DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_unit_step
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_rem,
    input  logic                  i_bit,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH-1:0] o_rem_c,
    output logic                  o_qbit_c
);

    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH+1:0] w_diff;
    logic                  w_unused_msb;

    assign w_shift  = {i_rem, i_bit};
    assign w_diff   = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_qbit_c = ~w_diff[DATA_WIDTH+1];
    // The kept remainder is always below the divisor, so its top bit is dropped.
    assign o_rem_c  = o_qbit_c ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
    assign w_unused_msb = w_diff[DATA_WIDTH];

endmodule

// File: rtl/div_unit.sv
// MIPS DIV/DIVU iterative divider: magnitude restoring division, then a sign-fix cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  div_valid,
    output logic                  div_ready,
    input  logic                  div_signed,
    input  logic [DATA_WIDTH-1:0] div_a,
    input  logic [DATA_WIDTH-1:0] div_b,
    input  logic                  cancel,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    div_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_dvd;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic [DATA_WIDTH-1:0] r_orig_a;
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic                  r_div0;
    logic                  r_div_ready;
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_quotient;
    logic [DATA_WIDTH-1:0] r_remainder;

    logic [DATA_WIDTH-1:0] w_abs_a;
    logic [DATA_WIDTH-1:0] w_abs_b;
    logic [DATA_WIDTH-1:0] w_step_rem;
    logic                  w_step_q;
    logic [DATA_WIDTH-1:0] w_q_fix;
    logic [DATA_WIDTH-1:0] w_r_fix;

    assign w_abs_a = (div_signed && div_a[DATA_WIDTH-1]) ? DATA_WIDTH'(-div_a) : div_a;
    assign w_abs_b = (div_signed && div_b[DATA_WIDTH-1]) ? DATA_WIDTH'(-div_b) : div_b;
    assign w_q_fix = r_q_neg ? DATA_WIDTH'(-r_dvd) : r_dvd;
    assign w_r_fix = r_r_neg ? DATA_WIDTH'(-r_rem) : r_rem;

    // The dividend register doubles as the quotient shift register.
    div_unit_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[DATA_WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem_c   (w_step_rem),
        .o_qbit_c  (w_step_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_orig_a    <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_div0      <= 1'b0;
            r_div_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (cancel) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_div_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_valid && r_div_ready) begin
                        r_state     <= S_CALC;
                        r_div_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_rem       <= '0;
                        r_dvd       <= w_abs_a;
                        r_dvs       <= w_abs_b;
                        r_orig_a    <= div_a;
                        r_q_neg     <= div_signed & (div_a[DATA_WIDTH-1] ^ div_b[DATA_WIDTH-1]);
                        r_r_neg     <= div_signed & div_a[DATA_WIDTH-1];
                        r_div0      <= (div_b == '0);
                    end
                end
                S_CALC: begin
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[DATA_WIDTH-2:0], w_step_q};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quotient  <= r_div0 ? '1 : w_q_fix;
                    r_remainder <= r_div0 ? r_orig_a : w_r_fix;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    // Valid is raised one cycle after the results settle, then held until taken.
                    if (!r_res_valid) begin
                        r_res_valid <= 1'b1;
                    end else if (res_ready) begin
                        r_state     <= S_IDLE;
                        r_res_valid <= 1'b0;
                        r_div_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign div_ready = r_div_ready;
    assign res_valid = r_res_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random ops vs. arithmetic model, corner sequences.
module tb_div_unit;

    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        cancel;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    div_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_a      (div_a),
        .div_b      (div_b),
        .cancel     (cancel),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // MIPS semantics from plain integer arithmetic.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Waits for div_ready, presents operands, returns #1 after the accepting edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!div_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("issue_timeout", 32'd1, 32'd0);
        div_valid  = 1'b1;
        div_signed = sgn;
        div_a      = a;
        div_b      = b;
        @(posedge clk); #1;
        div_valid  = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (res_valid) break;
            if (div_ready) rdy_seen = 1'b1;
        end
        if (!res_valid) chk("result_timeout", 32'd0, 32'd1);
        if (div_ready) rdy_seen = 1'b1;
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int   lat;
        logic rdy;
        issue(sgn, a, b);
        wait_result(lat, rdy);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_lat"}, 32'(lat), 32'(LAT));
        chk({tag, "_busy"}, 32'(rdy), 32'd0);
        take();
    endtask

    vec_t tbl[10];

    initial begin
        logic [31:0] eq, er, hq, hr;
        logic        stable;
        int          lat;
        logic        rdy;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        tbl[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        tbl[4] = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
        tbl[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        tbl[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        tbl[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        tbl[8] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9};
        tbl[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};

        resetn = 1'b0; div_valid = 1'b0; div_signed = 1'b0;
        div_a = '0; div_b = '0; cancel = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst_ready", 32'(div_ready), 32'd1);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r);

        for (int i = 0; i < 24; i++) begin
            logic        sg;
            logic [31:0] a, b;
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0;
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i % 5 == 0) b = -b;
            ref_div(sg, a, b, eq, er);
            run_check($sformatf("rnd%0d", i), sg, a, b, eq, er);
        end

        // Cancel mid-CALC, then an immediate fresh divide.
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_valid", 32'(res_valid), 32'd0);
        chk("cancel_ready", 32'(div_ready), 32'd1);
        run_check("post_cancel", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Cancel while holding DONE drops the result.
        issue(1'b0, 32'd50, 32'd5);
        wait_result(lat, rdy);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_done_valid", 32'(res_valid), 32'd0);
        chk("cancel_done_ready", 32'(div_ready), 32'd1);

        // Backpressure: result holds in DONE.
        issue(1'b1, 32'hFFFF_FC18, 32'd7);
        wait_result(lat, rdy);
        hq = quotient; hr = remainder;
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!res_valid || quotient !== hq || remainder !== hr || div_ready) stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_q", hq, 32'hFFFF_FF72);
        chk("bp_r", hr, 32'hFFFF_FFFA);
        take();
        chk("bp_done_valid", 32'(res_valid), 32'd0);
        chk("bp_done_ready", 32'(div_ready), 32'd1);

        // Asynchronous reset mid-CALC.
        issue(1'b0, 32'd77, 32'd5);
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_rst_busy", 32'(div_ready), 32'd0);
        resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_ready", 32'(div_ready), 32'd1);
        chk("arst_q", quotient, 32'd0);
        chk("arst_r", remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        run_check("post_rst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
